// File: rtl/cpu_types_pkg.sv
// Shared cache types: address split, frame layout, controller states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_types_pkg;

  localparam int DTAG_W = 25;
  localparam int DIDX_W = 4;
  localparam int DWORDS = 2;

  // Byte address as seen by the cache: tag | set index | word-in-block | byte.
  typedef struct packed {
    logic [DTAG_W-1:0] tag;
    logic [DIDX_W-1:0] idx;
    logic              blkoff;
    logic [1:0]        bytoff;
  } dcache_addr_t;

  typedef struct packed {
    logic                    valid;
    logic                    dirty;
    logic [DTAG_W-1:0]       tag;
    logic [DWORDS-1:0][31:0] data;
  } dcache_frame_t;

  typedef enum logic [3:0] {
    IDLE, WB0, WB1, LD0, LD1, FCHK, FWB0, FWB1, DONE
  } dcache_state_t;

endpackage

// File: rtl/dcache_frames.sv
// Frame store for the direct-mapped data cache: SETS x {valid, dirty, tag, data}.
// Latency: read is combinational; writes land at the next CLK edge.
// Backpressure: none; the owner sequences every write.
// Ports: rd_idx/rd_frame read port; wr_* write port (per-word data enable plus
// a meta enable for valid/dirty/tag); RST asynchronously clears valid and dirty.
module dcache_frames
  import cpu_types_pkg::*;
#(
  parameter int SETS = 16
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [DIDX_W-1:0]   rd_idx,
  output dcache_frame_t       rd_frame,
  input  logic [DIDX_W-1:0]   wr_idx,
  input  logic [DWORDS-1:0]   wr_word_en,
  input  logic [31:0]         wr_word,
  input  logic                wr_meta_en,
  input  logic                wr_valid,
  input  logic                wr_dirty,
  input  logic [DTAG_W-1:0]   wr_tag
);

  logic [SETS-1:0]         valid_q;
  logic [SETS-1:0]         dirty_q;
  logic [DTAG_W-1:0]       tag_q  [SETS];
  logic [DWORDS-1:0][31:0] data_q [SETS];

  always_comb begin
    rd_frame       = '0;
    rd_frame.valid = valid_q[rd_idx];
    rd_frame.dirty = dirty_q[rd_idx];
    rd_frame.tag   = tag_q[rd_idx];
    rd_frame.data  = data_q[rd_idx];
  end

  // Only the state bits are reset; tag/data are don't-care while invalid.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (wr_meta_en) begin
      valid_q[wr_idx] <= wr_valid;
      dirty_q[wr_idx] <= wr_dirty;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_meta_en) tag_q[wr_idx] <= wr_tag;
    for (int w = 0; w < DWORDS; w++) begin
      if (wr_word_en[w]) data_q[wr_idx][w] <= wr_word;
    end
  end

endmodule

// File: rtl/dcache_wb.sv
// Direct-mapped write-back L1 data cache with halt-time flush of dirty blocks.
// Latency: hits are combinational (dhit same cycle); clean miss = 2 memory
//   accesses + 1 cycle, dirty miss adds the 2-word writeback first.
// Backpressure: dhit low stalls the pipeline; memory side holds requests
//   while dwait is high.
// Ports: dmem* datapath load/store, dhit/dmemload result; dREN/dWEN/daddr/
//   dstore/dwait/dload memory controller; halt in, flushed out (sticky).
module dcache_wb
  import cpu_types_pkg::*;
#(
  parameter int SETS = 16,
  parameter int WPB  = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  input  logic        halt,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        flushed,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  input  logic        dwait,
  input  logic [31:0] dload
);

  dcache_state_t            state, state_nxt;
  logic [DIDX_W-1:0]        flush_idx, flush_idx_nxt;
  dcache_addr_t             req;
  dcache_frame_t            cur;
  logic [DIDX_W-1:0]        rd_idx;
  logic                     flushing, req_vld, hit, last_idx;
  logic [$clog2(WPB)-1:0]   mem_word;
  logic                     unused_bytoff;

  logic [DWORDS-1:0]        wr_word_en;
  logic [31:0]              wr_word;
  logic                     wr_meta_en, wr_valid, wr_dirty;
  logic [DTAG_W-1:0]        wr_tag;

  assign req           = dmemaddr;
  assign unused_bytoff = ^req.bytoff;
  assign req_vld       = dmemREN | dmemWEN;
  assign flushing      = state inside {FCHK, FWB0, FWB1, DONE};
  // The flush walk owns the frame port once it starts; otherwise the request does.
  assign rd_idx        = flushing ? flush_idx : req.idx;
  assign hit           = (state == IDLE) & !halt & cur.valid &
                         (cur.tag == req.tag) & req_vld;
  assign last_idx      = (flush_idx == DIDX_W'(SETS - 1));
  assign mem_word      = (state inside {WB1, LD1, FWB1});

  dcache_frames #(.SETS(SETS)) u_frames (
    .CLK        (CLK),
    .RST        (RST),
    .rd_idx     (rd_idx),
    .rd_frame   (cur),
    .wr_idx     (rd_idx),
    .wr_word_en (wr_word_en),
    .wr_word    (wr_word),
    .wr_meta_en (wr_meta_en),
    .wr_valid   (wr_valid),
    .wr_dirty   (wr_dirty),
    .wr_tag     (wr_tag)
  );

  // Memory-side outputs decode straight from state, so they drop with RST.
  always_comb begin
    dhit     = hit;
    dmemload = hit ? cur.data[req.blkoff] : '0;
    dREN     = state inside {LD0, LD1};
    dWEN     = state inside {WB0, WB1, FWB0, FWB1};
    flushed  = (state == DONE);
    daddr    = '0;
    dstore   = '0;
    if (dWEN) begin
      daddr  = {cur.tag, rd_idx, mem_word, 2'b00};
      dstore = cur.data[mem_word];
    end else if (dREN) begin
      daddr  = {req.tag, req.idx, mem_word, 2'b00};
    end
  end

  always_comb begin
    state_nxt     = state;
    flush_idx_nxt = flush_idx;
    wr_word_en    = '0;
    wr_word       = '0;
    wr_meta_en    = 1'b0;
    wr_valid      = 1'b0;
    wr_dirty      = 1'b0;
    wr_tag        = cur.tag;
    case (state)
      IDLE: begin
        if (halt) begin
          state_nxt = FCHK;
        end else if (hit) begin
          if (dmemWEN) begin  // store wins if both strobes are high
            wr_word_en[req.blkoff] = 1'b1;
            wr_word    = dmemstore;
            wr_meta_en = 1'b1;
            wr_valid   = 1'b1;
            wr_dirty   = 1'b1;
            wr_tag     = req.tag;
          end
        end else if (req_vld) begin
          state_nxt = (cur.valid && cur.dirty) ? WB0 : LD0;
        end
      end
      WB0: if (!dwait) state_nxt = WB1;
      WB1: if (!dwait) state_nxt = LD0;
      LD0: begin
        if (!dwait) begin
          wr_word_en[0] = 1'b1;
          wr_word       = dload;
          state_nxt     = LD1;
        end
      end
      LD1: begin
        // Block becomes valid only once both words are in.
        if (!dwait) begin
          wr_word_en[1] = 1'b1;
          wr_word       = dload;
          wr_meta_en    = 1'b1;
          wr_valid      = 1'b1;
          wr_tag        = req.tag;
          state_nxt     = IDLE;
        end
      end
      FCHK: begin
        if (cur.valid && cur.dirty) state_nxt = FWB0;
        else if (last_idx)          state_nxt = DONE;
        else                        flush_idx_nxt = flush_idx + 1'b1;
      end
      FWB0: if (!dwait) state_nxt = FWB1;
      FWB1: begin
        if (!dwait) begin
          wr_meta_en = 1'b1;
          wr_valid   = 1'b1;
          if (last_idx) begin
            state_nxt = DONE;
          end else begin
            state_nxt     = FCHK;
            flush_idx_nxt = flush_idx + 1'b1;
          end
        end
      end
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      flush_idx <= '0;
    end else begin
      state     <= state_nxt;
      flush_idx <= flush_idx_nxt;
    end
  end

endmodule

// File: tb/tb_dcache_wb.sv
// Self-checking bench for dcache_wb: memory model with fixed 2-cycle access,
// scoreboard queue of expected memory accesses, shadow copy of memory for loads.
module tb_dcache_wb;

  localparam int LAT = 2;

  logic        CLK = 1'b0;
  logic        RST;
  logic        dmemREN, dmemWEN, halt;
  logic [31:0] dmemaddr, dmemstore;
  logic        dhit, flushed, dREN, dWEN, dwait;
  logic [31:0] dmemload, daddr, dstore, dload;

  logic [31:0] mem   [0:4095];
  logic [31:0] model [0:4095];
  int          cnt;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } acc_t;
  acc_t exp_q [$];

  int vectors;
  int miscompares;

  always #5 CLK = ~CLK;

  assign dwait = !((dREN || dWEN) && cnt >= LAT - 1);
  assign dload = mem[daddr[13:2]];

  dcache_wb #(.SETS(16), .WPB(2)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .dmemREN   (dmemREN),
    .dmemWEN   (dmemWEN),
    .dmemaddr  (dmemaddr),
    .dmemstore (dmemstore),
    .halt      (halt),
    .dhit      (dhit),
    .dmemload  (dmemload),
    .flushed   (flushed),
    .dREN      (dREN),
    .dWEN      (dWEN),
    .daddr     (daddr),
    .dstore    (dstore),
    .dwait     (dwait),
    .dload     (dload)
  );

  // One clock: checks any memory access completing this cycle against the
  // scoreboard, then advances the memory latency counter. Returns at posedge+1.
  task automatic cycle();
    logic act, comp;
    acc_t e;
    @(negedge CLK);
    act  = dREN || dWEN;
    comp = act && !dwait && !RST;
    if (act) begin
      vectors++;
      if (dREN && dWEN) begin
        miscompares++;
        $display("FAIL bus_excl: dREN=%b dWEN=%b, required not both high", dREN, dWEN);
      end
    end
    if (comp) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_access: we=%b addr=%h data=%h, none expected", dWEN, daddr, dstore);
      end else begin
        e = exp_q.pop_front();
        if (dWEN !== e.we || daddr !== e.addr || (e.we && dstore !== e.data)) begin
          miscompares++;
          $display("FAIL mem_access: got we=%b addr=%h data=%h, required we=%b addr=%h data=%h",
                   dWEN, daddr, dstore, e.we, e.addr, e.data);
        end
      end
      if (dWEN) mem[daddr[13:2]] = dstore;
    end
    @(posedge CLK);
    #1;
    if (comp || !act) cnt = 0;
    else              cnt++;
  endtask

  task automatic expect_rd(input logic [31:0] addr);
    exp_q.push_back('{1'b0, addr, 32'h0});
  endtask

  task automatic expect_wr(input logic [31:0] addr);
    exp_q.push_back('{1'b1, addr, model[addr[13:2]]});
  endtask

  task automatic check_q_empty(input string name);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_pending: %0d accesses outstanding, required 0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  // Drive one datapath request and hold it until dhit; check latency and data.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input int exp_lat, input string name);
    int   n;
    logic got;
    dmemaddr  = addr;
    dmemstore = wdata;
    dmemWEN   = we;
    dmemREN   = !we;
    n   = 0;
    got = 1'b0;
    while (!got && n < 200) begin
      #1;
      if (dhit) got = 1'b1;
      else begin
        cycle();
        n++;
      end
    end
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL %s_timeout: no dhit after %0d cycles, required dhit", name, n);
    end else begin
      if (n !== exp_lat) begin
        miscompares++;
        $display("FAIL %s_latency: got %0d cycles, required %0d", name, n, exp_lat);
      end
      if (!we) begin
        vectors++;
        if (dmemload !== model[addr[13:2]]) begin
          miscompares++;
          $display("FAIL %s_data: got %h, required %h", name, dmemload, model[addr[13:2]]);
        end
      end else begin
        model[addr[13:2]] = wdata;
      end
    end
    cycle();
    dmemREN = 1'b0;
    dmemWEN = 1'b0;
  endtask

  task automatic do_reset();
    RST     = 1'b1;
    dmemREN = 1'b0;
    dmemWEN = 1'b0;
    halt    = 1'b0;
    #1;
    cycle();
    cycle();
    RST = 1'b0;
  endtask

  // Hold halt until flushed; check dhit never rises and the cycle count.
  task automatic run_flush(input int exp_cycles, input string name);
    int   n;
    logic seen_hit;
    n        = 0;
    seen_hit = 1'b0;
    while (n < 300) begin
      #1;
      if (flushed) break;
      if (dhit) seen_hit = 1'b1;
      cycle();
      n++;
    end
    vectors++;
    if (!flushed) begin
      miscompares++;
      $display("FAIL %s_timeout: flushed=%b after %0d cycles, required 1", name, flushed, n);
    end else if (exp_cycles >= 0 && n !== exp_cycles) begin
      miscompares++;
      $display("FAIL %s_cycles: flushed after %0d cycles, required %0d", name, n, exp_cycles);
    end
    vectors++;
    if (seen_hit) begin
      miscompares++;
      $display("FAIL %s_dhit: dhit=1 during flush, required 0", name);
    end
    check_q_empty(name);
  endtask

  task automatic test_reset();
    dmemREN  = 1'b1;
    dmemaddr = 32'h80;
    #2;
    vectors += 7;
    if (dhit !== 1'b0)     begin miscompares++; $display("FAIL rst_dhit: got %b, required 0", dhit); end
    if (dREN !== 1'b0)     begin miscompares++; $display("FAIL rst_dREN: got %b, required 0", dREN); end
    if (dWEN !== 1'b0)     begin miscompares++; $display("FAIL rst_dWEN: got %b, required 0", dWEN); end
    if (flushed !== 1'b0)  begin miscompares++; $display("FAIL rst_flushed: got %b, required 0", flushed); end
    if (daddr !== 32'h0)   begin miscompares++; $display("FAIL rst_daddr: got %h, required 0", daddr); end
    if (dstore !== 32'h0)  begin miscompares++; $display("FAIL rst_dstore: got %h, required 0", dstore); end
    if (dmemload !== 32'h0) begin miscompares++; $display("FAIL rst_dmemload: got %h, required 0", dmemload); end
    dmemREN = 1'b0;
    cycle();
    RST = 1'b0;
  endtask

  task automatic test_cold_load();
    expect_rd(32'h80);
    expect_rd(32'h84);
    access(1'b0, 32'h80, 32'h0, 5, "cold_80");
    access(1'b0, 32'h84, 32'h0, 0, "hit_84");
    check_q_empty("cold");
  endtask

  task automatic test_store_conflict();
    access(1'b1, 32'h80, 32'h1234, 0, "st_hit_80");
    expect_wr(32'h80);
    expect_wr(32'h84);
    expect_rd(32'h880);
    expect_rd(32'h884);
    access(1'b0, 32'h880, 32'h0, 9, "dirty_conf_880");
    check_q_empty("dirty_conf");
  endtask

  task automatic test_clean_conflict();
    expect_rd(32'h80);
    expect_rd(32'h84);
    access(1'b0, 32'h80, 32'h0, 5, "clean_80");
    expect_rd(32'h880);
    expect_rd(32'h884);
    access(1'b0, 32'h880, 32'h0, 5, "clean_880");
    access(1'b0, 32'h884, 32'h0, 0, "clean_hit_884");
    check_q_empty("clean_conf");
  endtask

  task automatic test_halt_flush();
    expect_rd(32'h00); expect_rd(32'h04);
    access(1'b1, 32'h00, 32'h1111_0000, 5, "dirty_set0");
    expect_rd(32'h28); expect_rd(32'h2C);
    access(1'b1, 32'h2C, 32'h5555_0005, 5, "dirty_set5");
    expect_rd(32'h78); expect_rd(32'h7C);
    access(1'b1, 32'h78, 32'hFFFF_000F, 5, "dirty_set15");
    check_q_empty("flush_setup");
    expect_wr(32'h00); expect_wr(32'h04);
    expect_wr(32'h28); expect_wr(32'h2C);
    expect_wr(32'h78); expect_wr(32'h7C);
    dmemREN  = 1'b1;
    dmemaddr = 32'h00;
    halt     = 1'b1;
    run_flush(29, "flush");
    for (int i = 0; i < 4; i++) begin
      cycle();
      vectors++;
      if (flushed !== 1'b1 || dhit !== 1'b0) begin
        miscompares++;
        $display("FAIL flush_sticky: flushed=%b dhit=%b, required 1/0", flushed, dhit);
      end
    end
    check_q_empty("flush_done");
    dmemREN = 1'b0;
  endtask

  task automatic test_halt_during_miss();
    do_reset();
    expect_rd(32'h40); expect_rd(32'h44);
    access(1'b1, 32'h44, 32'hCAFE_0044, 5, "dirty_set8");
    expect_rd(32'h200); expect_rd(32'h204);
    expect_wr(32'h40); expect_wr(32'h44);
    dmemREN  = 1'b1;
    dmemaddr = 32'h200;
    cycle();
    vectors++;
    if (dREN !== 1'b1 || daddr !== 32'h200) begin
      miscompares++;
      $display("FAIL hmiss_ld0: dREN=%b daddr=%h, required 1/00000200", dREN, daddr);
    end
    halt = 1'b1;
    run_flush(-1, "hmiss");
    dmemREN = 1'b0;
  endtask

  task automatic test_reset_mid_wb();
    int   n;
    logic found;
    do_reset();
    expect_rd(32'h80); expect_rd(32'h84);
    access(1'b1, 32'h80, 32'h5678, 5, "rwb_store");
    expect_wr(32'h80);
    dmemREN  = 1'b1;
    dmemaddr = 32'h880;
    found    = 1'b0;
    n        = 0;
    while (!found && n < 50) begin
      cycle();
      n++;
      if (dWEN && daddr == 32'h84) found = 1'b1;
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL rwb_reach_wb1: dWEN=%b daddr=%h, required 1/00000084", dWEN, daddr);
    end
    RST = 1'b1;
    #1;
    vectors++;
    if (dWEN !== 1'b0 || dREN !== 1'b0 || daddr !== 32'h0) begin
      miscompares++;
      $display("FAIL rwb_drop: dWEN=%b dREN=%b daddr=%h, required 0/0/0", dWEN, dREN, daddr);
    end
    dmemREN = 1'b0;
    cycle();
    RST = 1'b0;
    check_q_empty("rwb");
    expect_rd(32'h80); expect_rd(32'h84);
    access(1'b0, 32'h80, 32'h0, 5, "rwb_reload");
    check_q_empty("rwb_reload");
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    cnt         = 0;
    RST         = 1'b1;
    dmemREN     = 1'b0;
    dmemWEN     = 1'b0;
    halt        = 1'b0;
    dmemaddr    = 32'h0;
    dmemstore   = 32'h0;
    for (int i = 0; i < 4096; i++) mem[i] = 32'h5A00_0000 | i;
    mem[32'h20] = 32'h0000_AAAA;
    mem[32'h21] = 32'h0000_BBBB;
    for (int i = 0; i < 4096; i++) model[i] = mem[i];

    test_reset();
    test_cold_load();
    test_store_conflict();
    test_clean_conflict();
    test_halt_flush();
    test_halt_during_miss();
    test_reset_mid_wb();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
